// File: rtl/fetch_decode_frontend_if.sv
// Bundle between the RV32I fetch/decode front end, the instruction cache and rename.
// master = the front end; slave = the surrounding environment (cache, redirect source, rename).
// Handshake: the front end offers an instruction with valid_o. The instruction is consumed
// on a rising edge where valid_o=1 and ready_o=1. While ready_o=0, valid_o and every decoded
// field hold steady. cache_instruction_valid qualifies cache_instruction_data for the
// current cache_instruction_addr in the same cycle.
interface fetch_decode_frontend_if;
  logic        jump;
  logic [31:0] jump_addr;
  logic [31:0] cache_instruction_addr;
  logic [31:0] cache_instruction_data;
  logic        cache_instruction_valid;
  logic        valid_o;
  logic        ready_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;
  logic [4:0]  rd_o;
  logic [4:0]  rs1_o;
  logic [4:0]  rs2_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] imm_o;
  logic        uses_rd_o;
  logic        uses_rs1_o;
  logic        uses_rs2_o;
  logic        illegal_o;

  modport master (
    input  jump, jump_addr, cache_instruction_data, cache_instruction_valid, ready_o,
    output cache_instruction_addr, valid_o, pc_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, imm_o, uses_rd_o, uses_rs1_o, uses_rs2_o, illegal_o
  );

  modport slave (
    output jump, jump_addr, cache_instruction_data, cache_instruction_valid, ready_o,
    input  cache_instruction_addr, valid_o, pc_o, opcode_o, rd_o, rs1_o, rs2_o,
           funct3_o, funct7_o, imm_o, uses_rd_o, uses_rs1_o, uses_rs2_o, illegal_o
  );
endinterface

// File: rtl/fetch_decode_frontend.sv
// Two-stage RV32I front end: fetch register (PC, cache capture, redirect) then decode register.
// Optional macro FETCH_DECODE_X0_SUPPRESS_EN clears uses_rd_o for instructions writing x0.
module fetch_decode_frontend #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int          XLEN       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  fetch_decode_frontend_if.master bus
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [XLEN-1:0] r_pc;
  logic            r_f_valid;
  logic [31:0]     r_f_instr;
  logic [XLEN-1:0] r_f_pc;

  logic            r_d_valid;
  logic [XLEN-1:0] r_d_pc;
  logic [6:0]      r_d_opcode;
  logic [4:0]      r_d_rd;
  logic [4:0]      r_d_rs1;
  logic [4:0]      r_d_rs2;
  logic [2:0]      r_d_funct3;
  logic [6:0]      r_d_funct7;
  logic [XLEN-1:0] r_d_imm;
  logic            r_d_uses_rd;
  logic            r_d_uses_rs1;
  logic            r_d_uses_rs2;
  logic            r_d_illegal;

  logic            w_d_load;
  logic            w_f_accept;
  logic [6:0]      w_opcode;
  logic [XLEN-1:0] w_imm;
  logic            w_uses_rd;
  logic            w_uses_rs1;
  logic            w_uses_rs2;
  logic            w_illegal;

  // Fetch may refill in the same cycle its current entry moves into decode.
  assign w_d_load   = r_f_valid && (!r_d_valid || bus.ready_o);
  assign w_f_accept = bus.cache_instruction_valid && (!r_f_valid || w_d_load);
  assign w_opcode   = r_f_instr[6:0];

  always_comb begin
    w_imm      = '0;
    w_uses_rd  = 1'b0;
    w_uses_rs1 = 1'b0;
    w_uses_rs2 = 1'b0;
    w_illegal  = 1'b0;
    case (w_opcode)
      OP_IMM, OP_LOAD, OP_JALR, OP_SYSTEM: begin
        w_imm      = {{20{r_f_instr[31]}}, r_f_instr[31:20]};
        w_uses_rd  = 1'b1;
        w_uses_rs1 = 1'b1;
      end
      OP_STORE: begin
        w_imm      = {{20{r_f_instr[31]}}, r_f_instr[31:25], r_f_instr[11:7]};
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_BRANCH: begin
        w_imm      = {{19{r_f_instr[31]}}, r_f_instr[31], r_f_instr[7],
                      r_f_instr[30:25], r_f_instr[11:8], 1'b0};
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_LUI, OP_AUIPC: begin
        w_imm      = {r_f_instr[31:12], 12'b0};
        w_uses_rd  = 1'b1;
      end
      OP_JAL: begin
        w_imm      = {{11{r_f_instr[31]}}, r_f_instr[31], r_f_instr[19:12],
                      r_f_instr[20], r_f_instr[30:21], 1'b0};
        w_uses_rd  = 1'b1;
      end
      OP_REG: begin
        w_uses_rd  = 1'b1;
        w_uses_rs1 = 1'b1;
        w_uses_rs2 = 1'b1;
      end
      OP_FENCE: begin
        w_imm      = '0;
      end
      default: begin
        w_illegal  = 1'b1;
      end
    endcase
`ifdef FETCH_DECODE_X0_SUPPRESS_EN
    if (r_f_instr[11:7] == 5'd0) w_uses_rd = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc         <= RESET_ADDR;
      r_f_valid    <= 1'b0;
      r_f_instr    <= '0;
      r_f_pc       <= '0;
      r_d_valid    <= 1'b0;
      r_d_pc       <= '0;
      r_d_opcode   <= '0;
      r_d_rd       <= '0;
      r_d_rs1      <= '0;
      r_d_rs2      <= '0;
      r_d_funct3   <= '0;
      r_d_funct7   <= '0;
      r_d_imm      <= '0;
      r_d_uses_rd  <= 1'b0;
      r_d_uses_rs1 <= 1'b0;
      r_d_uses_rs2 <= 1'b0;
      r_d_illegal  <= 1'b0;
    end else if (bus.jump) begin
      // Redirect squashes both stages and drops this cycle's cache response.
      r_pc      <= {bus.jump_addr[31:2], 2'b00};
      r_f_valid <= 1'b0;
      r_d_valid <= 1'b0;
    end else begin
      if (w_f_accept) begin
        r_f_valid <= 1'b1;
        r_f_instr <= bus.cache_instruction_data;
        r_f_pc    <= r_pc;
        r_pc      <= r_pc + 32'd4;
      end else if (w_d_load) begin
        r_f_valid <= 1'b0;
      end

      if (w_d_load) begin
        r_d_valid    <= 1'b1;
        r_d_pc       <= r_f_pc;
        r_d_opcode   <= w_opcode;
        r_d_rd       <= r_f_instr[11:7];
        r_d_rs1      <= r_f_instr[19:15];
        r_d_rs2      <= r_f_instr[24:20];
        r_d_funct3   <= r_f_instr[14:12];
        r_d_funct7   <= r_f_instr[31:25];
        r_d_imm      <= w_imm;
        r_d_uses_rd  <= w_uses_rd;
        r_d_uses_rs1 <= w_uses_rs1;
        r_d_uses_rs2 <= w_uses_rs2;
        r_d_illegal  <= w_illegal;
      end else if (bus.ready_o) begin
        r_d_valid <= 1'b0;
      end
    end
  end

  assign bus.cache_instruction_addr = r_pc;
  assign bus.valid_o    = r_d_valid;
  assign bus.pc_o       = r_d_pc;
  assign bus.opcode_o   = r_d_opcode;
  assign bus.rd_o       = r_d_rd;
  assign bus.rs1_o      = r_d_rs1;
  assign bus.rs2_o      = r_d_rs2;
  assign bus.funct3_o   = r_d_funct3;
  assign bus.funct7_o   = r_d_funct7;
  assign bus.imm_o      = r_d_imm;
  assign bus.uses_rd_o  = r_d_uses_rd;
  assign bus.uses_rs1_o = r_d_uses_rs1;
  assign bus.uses_rs2_o = r_d_uses_rs2;
  assign bus.illegal_o  = r_d_illegal;

endmodule

// File: tb/tb_fetch_decode_frontend.sv
// Directed bench for fetch_decode_frontend: a small instruction memory answers the cache
// port, and a linear sequence of steps checks decoded outputs against hand-computed values.
module tb_fetch_decode_frontend;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  logic [31:0] mem [0:127];

  fetch_decode_frontend_if bus ();

  fetch_decode_frontend #(.RESET_ADDR(32'h0000_0000), .XLEN(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.cache_instruction_data = mem[bus.cache_instruction_addr[8:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    // Default word at index i: addi x2, x0, i  (imm_o identifies the instruction).
    for (int i = 0; i < 128; i++) mem[i] = (32'(i) << 20) | 32'h0000_0113;
    mem[0]  = 32'h0050_0093;  // addi x1, x0, 5
    mem[1]  = 32'hFE00_0EE3;  // beq x0, x0, -4
    mem[2]  = 32'h0000_007F;  // illegal opcode
    mem[3]  = 32'h0000_0013;  // addi x0, x0, 0
    mem[64] = 32'h1234_51B7;  // lui x3, 0x12345 at 0x100

    reset = 1'b1;
    bus.jump = 1'b0;
    bus.jump_addr = 32'h0;
    bus.cache_instruction_valid = 1'b0;
    bus.ready_o = 1'b1;
    #1;
    chk("rst_addr", bus.cache_instruction_addr, 32'h0);
    chk("rst_valid", {31'b0, bus.valid_o}, 32'h0);
    chk("rst_pc", bus.pc_o, 32'h0);
    chk("rst_imm", bus.imm_o, 32'h0);
    chk("rst_rd", {27'b0, bus.rd_o}, 32'h0);
    step();
    step();
    reset = 1'b0;
    bus.cache_instruction_valid = 1'b1;

    step();  // word at 0 accepted into fetch
    chk("fill_addr4", bus.cache_instruction_addr, 32'h4);
    chk("fill_valid0", {31'b0, bus.valid_o}, 32'h0);

    step();  // addi x1,x0,5 in decode
    chk("addi_valid", {31'b0, bus.valid_o}, 32'h1);
    chk("addi_pc", bus.pc_o, 32'h0);
    chk("addi_addr8", bus.cache_instruction_addr, 32'h8);
    chk("addi_opcode", {25'b0, bus.opcode_o}, 32'h13);
    chk("addi_rd", {27'b0, bus.rd_o}, 32'h1);
    chk("addi_rs1", {27'b0, bus.rs1_o}, 32'h0);
    chk("addi_imm", bus.imm_o, 32'h5);
    chk("addi_uses_rd", {31'b0, bus.uses_rd_o}, 32'h1);
    chk("addi_uses_rs1", {31'b0, bus.uses_rs1_o}, 32'h1);
    chk("addi_uses_rs2", {31'b0, bus.uses_rs2_o}, 32'h0);
    chk("addi_illegal", {31'b0, bus.illegal_o}, 32'h0);

    step();  // beq x0,x0,-4
    chk("beq_pc", bus.pc_o, 32'h4);
    chk("beq_opcode", {25'b0, bus.opcode_o}, 32'h63);
    chk("beq_imm", bus.imm_o, 32'hFFFF_FFFC);
    chk("beq_funct7", {25'b0, bus.funct7_o}, 32'h7F);
    chk("beq_uses_rd", {31'b0, bus.uses_rd_o}, 32'h0);
    chk("beq_uses_rs1", {31'b0, bus.uses_rs1_o}, 32'h1);
    chk("beq_uses_rs2", {31'b0, bus.uses_rs2_o}, 32'h1);

    step();  // illegal opcode 7F
    chk("ill_pc", bus.pc_o, 32'h8);
    chk("ill_valid", {31'b0, bus.valid_o}, 32'h1);
    chk("ill_flag", {31'b0, bus.illegal_o}, 32'h1);
    chk("ill_uses", {29'b0, bus.uses_rd_o, bus.uses_rs1_o, bus.uses_rs2_o}, 32'h0);

    step();  // addi x0,x0,0
    chk("x0_pc", bus.pc_o, 32'hC);
    chk("x0_rd", {27'b0, bus.rd_o}, 32'h0);
    chk("x0_imm", bus.imm_o, 32'h0);
`ifdef FETCH_DECODE_X0_SUPPRESS_EN
    chk("x0_uses_rd", {31'b0, bus.uses_rd_o}, 32'h0);
`else
    chk("x0_uses_rd", {31'b0, bus.uses_rd_o}, 32'h1);
`endif

    step();  // pc 0x10 in decode, 0x14 in fetch, PC at 0x18
    chk("pre_stall_pc", bus.pc_o, 32'h10);
    bus.ready_o = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_valid", {31'b0, bus.valid_o}, 32'h1);
      chk("stall_pc", bus.pc_o, 32'h10);
      chk("stall_imm", bus.imm_o, 32'h4);
      chk("stall_addr", bus.cache_instruction_addr, 32'h18);
    end
    bus.ready_o = 1'b1;

    step();
    chk("resume_pc14", bus.pc_o, 32'h14);
    chk("resume_imm5", bus.imm_o, 32'h5);
    chk("resume_addr", bus.cache_instruction_addr, 32'h1C);
    step();
    chk("resume_pc18", bus.pc_o, 32'h18);
    chk("resume_imm6", bus.imm_o, 32'h6);
    bus.cache_instruction_valid = 1'b0;

    step();  // fetch drains 0x1C, nothing accepted
    chk("gap_pc1c", bus.pc_o, 32'h1C);
    chk("gap_addr", bus.cache_instruction_addr, 32'h20);
    bus.cache_instruction_valid = 1'b1;
    step();
    chk("gap_valid0", {31'b0, bus.valid_o}, 32'h0);
    chk("gap_addr24", bus.cache_instruction_addr, 32'h24);
    step();
    chk("gap_pc20", bus.pc_o, 32'h20);
    chk("gap_valid1", {31'b0, bus.valid_o}, 32'h1);
    chk("gap_imm8", bus.imm_o, 32'h8);

    bus.jump = 1'b1;
    bus.jump_addr = 32'h0000_0103;
    step();
    chk("jmp_valid0", {31'b0, bus.valid_o}, 32'h0);
    chk("jmp_addr", bus.cache_instruction_addr, 32'h100);
    bus.jump = 1'b0;
    step();
    chk("jmp_fill_valid", {31'b0, bus.valid_o}, 32'h0);
    chk("jmp_fill_addr", bus.cache_instruction_addr, 32'h104);
    step();
    chk("lui_valid", {31'b0, bus.valid_o}, 32'h1);
    chk("lui_pc", bus.pc_o, 32'h100);
    chk("lui_imm", bus.imm_o, 32'h1234_5000);
    chk("lui_rd", {27'b0, bus.rd_o}, 32'h3);
    chk("lui_uses_rs1", {31'b0, bus.uses_rs1_o}, 32'h0);
    step();
    chk("post_jmp_pc", bus.pc_o, 32'h104);
    chk("post_jmp_imm", bus.imm_o, 32'd65);

    reset = 1'b1;
    #1;
    chk("mid_rst_valid", {31'b0, bus.valid_o}, 32'h0);
    chk("mid_rst_addr", bus.cache_instruction_addr, 32'h0);
    chk("mid_rst_imm", bus.imm_o, 32'h0);
    step();
    reset = 1'b0;
    step();
    chk("rerun_valid0", {31'b0, bus.valid_o}, 32'h0);
    step();
    chk("rerun_valid1", {31'b0, bus.valid_o}, 32'h1);
    chk("rerun_pc", bus.pc_o, 32'h0);
    chk("rerun_imm", bus.imm_o, 32'h5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_decode_frontend.md
Name: fetch_decode_frontend

Overview:
- In-order RV32I front end: a fetch stage (PC generation, instruction-cache request, redirect) feeding a decode stage (field extraction, immediate generation, operand-use flags).
- Sits between the instruction cache and the register-rename stage.
- Two-stage valid/ready pipeline. Every stage register holds at most one instruction.

Parameters:
- RESET_ADDR, 32'h0000_0000, PC value loaded on reset.
- XLEN, 32, width of data, PC and immediates (only 32 is supported).

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- reset  in  1  Asynchronous, active-high reset.
- jump  in  1  Redirect request; takes priority over all other events.
- jump_addr  in  32  Redirect target; bits [1:0] are ignored (forced to 0).
- cache_instruction_addr  out  32  Fetch address, equal to the current PC.
- cache_instruction_data  in  32  Instruction word for cache_instruction_addr.
- cache_instruction_valid  in  1  cache_instruction_data is valid this cycle.
- valid_o  out  1  Decoded instruction valid.
- ready_o  in  1  Downstream can accept. The codebase names this port ready_o even though it is an input.
- pc_o  out  32  PC of the decoded instruction.
- opcode_o  out  7  instr[6:0].
- rd_o, rs1_o, rs2_o  out  5 each  instr[11:7], instr[19:15], instr[24:20].
- funct3_o  out  3  instr[14:12].
- funct7_o  out  7  instr[31:25].
- imm_o  out  32  Sign-extended immediate for the instruction format.
- uses_rd_o, uses_rs1_o, uses_rs2_o  out  1 each  Operand-use flags.
- illegal_o  out  1  Opcode is not an RV32I base opcode.

Behaviour:
- Reset (asynchronous):
  - PC = RESET_ADDR; fetch-stage valid = 0; decode-stage valid = 0.
  - All decoded outputs = 0; valid_o = 0.
- cache_instruction_addr is driven combinationally from the PC.
- Fetch stage accepts when cache_instruction_valid=1 and its register is empty or is being drained into decode this cycle.
- On fetch accept: capture {data, PC}, then PC += 4, wrapping modulo 2^32.
- While the fetch stage cannot accept, the PC holds and the cache address stays stable.
- Decode stage loads from fetch when fetch is valid and (decode is empty or ready_o=1). Decode logic is combinational on the fetch register, registered into the decode stage.
- Latency: 2 cycles from a cache-valid accept to valid_o with no stalls. Throughput: 1 instruction per cycle.
- valid_o holds, and all outputs stay stable, while ready_o=0. The instruction is consumed in a cycle where valid_o=1 and ready_o=1.
- jump=1 on a rising edge:
  - PC = {jump_addr[31:2], 2'b00}; both stage valids are cleared.
  - Any cache response that cycle is discarded.
  - The first instruction after a jump appears 2 cycles after the first cache-valid cycle at the new PC.
- Immediates:
  - I-type (opcodes 0010011, 0000011, 1100111, 1110011): instr[31:20].
  - S-type (0100011): {instr[31:25], instr[11:7]}.
  - B-type (1100011): {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
  - U-type (0110111, 0010111): {instr[31:12], 12'b0}.
  - J-type (1101111): {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
  - All immediates are sign-extended from the top bit. R-type (0110011) and fence (0001111) give imm=0.
- Operand-use flags:
  - uses_rd_o = 0 for S, B and fence.
  - uses_rs1_o = 0 for U, J and fence.
  - uses_rs2_o = 1 only for R, S and B.
- Illegal opcodes: illegal_o=1, all use flags are 0, and the instruction is still passed downstream with valid_o=1.
- A mid-stream reset discards all in-flight instructions.

Optional Feature:
- Macro FETCH_DECODE_X0_SUPPRESS_EN.
- Defined: uses_rd_o is forced to 0 whenever rd_o==0, so writes to x0 are never renamed.
- Undefined: uses_rd_o depends only on format; rd=x0 writers report uses_rd_o=1.

Test Plan:
- Reset release, cache always valid returning 32'h00500093 (addi x1,x0,5) -> cache_instruction_addr steps 0,4,8…; first valid_o 2 cycles after the first accept with pc_o=0, rd_o=1, rs1_o=0, imm_o=5, uses_rs2_o=0.
- Word 32'hFE000EE3 (beq x0,x0,-4) -> imm_o=32'hFFFFFFFC, uses_rd_o=0, uses_rs2_o=1.
- ready_o=0 for 5 cycles -> valid_o and outputs stay stable, PC stops advancing after both stages fill, no instruction is lost or duplicated after ready_o returns.
- jump=1 with jump_addr=32'h103 while the pipeline is full -> valid_o drops next cycle, cache_instruction_addr=32'h100, next pc_o=32'h100.
- cache_instruction_valid toggling 1,0,1 -> only valid cycles advance the PC; pc_o sequence is contiguous.
- Word 32'h0000007F -> illegal_o=1, valid_o=1, all use flags 0. Word 32'h00000013 with FETCH_DECODE_X0_SUPPRESS_EN defined -> uses_rd_o=0; with it undefined -> uses_rd_o=1.
